// File: rtl/leds_axis_arb_pkg.sv
// Shared types and default sizing for the LED stream arbiter.
package leds_axis_arb_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_NUM_REQ    = 4;

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/leds_axis_arb_if.sv
// Requester/sink bundle of the LED stream arbiter; slave is the arbiter's view.
interface leds_axis_arb_if
  import leds_axis_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]            s_axis_tvalid_i;
  logic [NUM_REQ*DATA_WIDTH-1:0] s_axis_tdata_i;
  logic [NUM_REQ-1:0]            s_axis_tready_o;
  logic [NUM_REQ-1:0]            req_mask_i;
  logic                          m_axis_tvalid_o;
  logic [DATA_WIDTH-1:0]         m_axis_tdata_o;
  logic                          m_axis_tready_i;
  logic [ID_WIDTH-1:0]           grant_id_o;

  modport slave (
    input  s_axis_tvalid_i, s_axis_tdata_i, req_mask_i, m_axis_tready_i,
    output s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, grant_id_o
  );

  modport master (
    output s_axis_tvalid_i, s_axis_tdata_i, req_mask_i, m_axis_tready_i,
    input  s_axis_tready_o, m_axis_tvalid_o, m_axis_tdata_o, grant_id_o
  );

endinterface

// File: rtl/leds_axis_arb_rr_picker.sv
// Combinational round-robin picker: first eligible index above last_grant, wrapping.
module rr_picker #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned ID_WIDTH = 2
) (
  input  logic [NUM_REQ-1:0]  eligible,
  input  logic [ID_WIDTH-1:0] last_grant,
  output logic [ID_WIDTH-1:0] winner,
  output logic                any
);

  logic [ID_WIDTH-1:0] idx;

  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = ID_WIDTH'((32'(last_grant) + k) % NUM_REQ);
      if (!any && eligible[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/leds_axis_arb.sv
// Round-robin arbiter merging NUM_REQ AXI-Stream requesters onto one LED sink.
module leds_axis_arb
  import leds_axis_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
  parameter int unsigned ID_WIDTH   = $clog2(NUM_REQ)
) (
  input logic            axis_aclk_i,
  input logic            axis_areset_i,
  leds_axis_arb_if.slave bus
);

  state_t                state, state_next;
  logic [ID_WIDTH-1:0]   last_grant, last_grant_next;
  logic [ID_WIDTH-1:0]   held_id, held_id_next;
  logic [ID_WIDTH-1:0]   grant_id, grant_id_next;
  logic [ID_WIDTH-1:0]   winner;
  logic                  any_eligible;
  logic [DATA_WIDTH-1:0] data_q, data_next, winner_data;
  logic                  valid_q, valid_next;
  logic [NUM_REQ-1:0]    eligible, ready;

  assign eligible = bus.s_axis_tvalid_i & bus.req_mask_i;

  rr_picker #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant),
    .winner     (winner),
    .any        (any_eligible)
  );

  // Data mux for the current winner.
  always_comb begin
    winner_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (winner == ID_WIDTH'(i)) winner_data = bus.s_axis_tdata_i[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Next state; ready is only offered in ST_ARB and never while in reset.
  always_comb begin
    state_next      = state;
    valid_next      = valid_q;
    data_next       = data_q;
    held_id_next    = held_id;
    last_grant_next = last_grant;
    grant_id_next   = grant_id;
    ready           = '0;
    unique case (state)
      ST_ARB: begin
        if (any_eligible && !axis_areset_i) begin
          ready[winner] = 1'b1;
          data_next     = winner_data;
          valid_next    = 1'b1;
          held_id_next  = winner;
          state_next    = ST_SEND;
        end
      end
      ST_SEND: begin
        if (bus.m_axis_tready_i) begin
          valid_next      = 1'b0;
          last_grant_next = held_id;
          grant_id_next   = held_id;
          state_next      = ST_ARB;
        end
      end
    endcase
  end

  // Reset seeds last_grant so requester 0 wins first.
  always_ff @(posedge axis_aclk_i) begin
    if (axis_areset_i) begin
      state      <= ST_ARB;
      valid_q    <= 1'b0;
      data_q     <= '0;
      held_id    <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      grant_id   <= '0;
    end else begin
      state      <= state_next;
      valid_q    <= valid_next;
      data_q     <= data_next;
      held_id    <= held_id_next;
      last_grant <= last_grant_next;
      grant_id   <= grant_id_next;
    end
  end

  assign bus.s_axis_tready_o = ready;
  assign bus.m_axis_tvalid_o = valid_q;
  assign bus.m_axis_tdata_o  = data_q;
  assign bus.grant_id_o      = grant_id;

endmodule

// File: tb/tb_leds_axis_arb.sv
// Directed bench for leds_axis_arb: ordering, backpressure, masking, wrap, reset, idle.
module tb_leds_axis_arb;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned IW = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests   = 0;
  int   errors  = 0;
  int   acc_cnt = 0;
  bit   saw_55  = 1'b0;

  always #5 clk = ~clk;

  leds_axis_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

  leds_axis_arb #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .axis_aclk_i   (clk),
    .axis_areset_i (rst),
    .bus           (bus)
  );

  // Sink-side observer: a beat is taken on the next rising edge.
  always @(negedge clk) begin
    if (!rst && bus.m_axis_tvalid_o && bus.m_axis_tready_i) begin
      acc_cnt++;
      if (bus.m_axis_tdata_o == 8'h55) saw_55 = 1'b1;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.s_axis_tvalid_i = '0;
    bus.s_axis_tdata_i  = '0;
    bus.req_mask_i      = '1;
    bus.m_axis_tready_i = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.s_axis_tvalid_i = 4'b1111;
    bus.s_axis_tdata_i  = 32'hDEADBEEF;
    bus.req_mask_i      = 4'b1111;
    bus.m_axis_tready_i = 1'b1;
    step();
    step();
    tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL reset_tready got %b exp 0000", bus.s_axis_tready_o); end
    tests++; if (bus.m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", bus.m_axis_tvalid_o); end
    tests++; if (bus.m_axis_tdata_o !== 8'h00) begin errors++; $display("FAIL reset_tdata got %h exp 00", bus.m_axis_tdata_o); end
    tests++; if (bus.grant_id_o !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d exp 0", bus.grant_id_o); end
    bus.s_axis_tvalid_i = '0;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_rdy;
    int acc0;
    do_reset();
    acc0 = acc_cnt;
    bus.s_axis_tdata_i  = {8'h13, 8'h12, 8'h11, 8'h10};
    bus.s_axis_tvalid_i = 4'b1111;
    bus.m_axis_tready_i = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_rdy = 4'b0001 << k;
      tests++; if (bus.s_axis_tready_o !== exp_rdy) begin errors++; $display("FAIL rr_tready[%0d] got %b exp %b", k, bus.s_axis_tready_o, exp_rdy); end
      step();
      bus.s_axis_tvalid_i[k] = 1'b0;
      #1;
      tests++; if (bus.m_axis_tvalid_o !== 1'b1) begin errors++; $display("FAIL rr_tvalid[%0d] got %b exp 1", k, bus.m_axis_tvalid_o); end
      tests++; if (bus.m_axis_tdata_o !== DW'(8'h10 + k)) begin errors++; $display("FAIL rr_tdata[%0d] got %h exp %h", k, bus.m_axis_tdata_o, DW'(8'h10 + k)); end
      tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL rr_send_tready[%0d] got %b exp 0000", k, bus.s_axis_tready_o); end
      step();
      tests++; if (bus.m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL rr_gap[%0d] got %b exp 0", k, bus.m_axis_tvalid_o); end
      tests++; if (bus.grant_id_o !== IW'(k)) begin errors++; $display("FAIL rr_grant[%0d] got %0d exp %0d", k, bus.grant_id_o, k); end
    end
    tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL rr_drained got %b exp 0000", bus.s_axis_tready_o); end
    tests++; if (acc_cnt - acc0 !== 4) begin errors++; $display("FAIL rr_count got %0d exp 4", acc_cnt - acc0); end
  endtask

  task automatic test_backpressure();
    int acc0;
    do_reset();
    acc0 = acc_cnt;
    bus.s_axis_tdata_i  = {8'h00, 8'hA5, 8'h00, 8'h00};
    bus.s_axis_tvalid_i = 4'b0100;
    #1;
    tests++; if (bus.s_axis_tready_o !== 4'b0100) begin errors++; $display("FAIL bp_grant got %b exp 0100", bus.s_axis_tready_o); end
    step();
    bus.s_axis_tvalid_i = '0;
    for (int c = 0; c < 5; c++) begin
      if (c == 2) begin
        bus.req_mask_i      = 4'b0000;
        bus.s_axis_tvalid_i = 4'b1111;
      end
      #1;
      tests++; if (bus.m_axis_tvalid_o !== 1'b1) begin errors++; $display("FAIL bp_tvalid[%0d] got %b exp 1", c, bus.m_axis_tvalid_o); end
      tests++; if (bus.m_axis_tdata_o !== 8'hA5) begin errors++; $display("FAIL bp_tdata[%0d] got %h exp a5", c, bus.m_axis_tdata_o); end
      tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL bp_tready[%0d] got %b exp 0000", c, bus.s_axis_tready_o); end
      step();
    end
    bus.s_axis_tvalid_i = '0;
    bus.req_mask_i      = 4'b1111;
    bus.m_axis_tready_i = 1'b1;
    #1;
    tests++; if (bus.m_axis_tvalid_o !== 1'b1) begin errors++; $display("FAIL bp_still_held got %b exp 1", bus.m_axis_tvalid_o); end
    step();
    tests++; if (bus.m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL bp_release got %b exp 0", bus.m_axis_tvalid_o); end
    tests++; if (bus.grant_id_o !== 2'd2) begin errors++; $display("FAIL bp_grant_id got %0d exp 2", bus.grant_id_o); end
    step();
    step();
    tests++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL bp_count got %0d exp 1", acc_cnt - acc0); end
  endtask

  task automatic test_mask();
    int ids [4] = '{1, 3, 1, 3};
    logic [3:0] exp_rdy;
    do_reset();
    bus.s_axis_tdata_i  = {8'h23, 8'h22, 8'h21, 8'h20};
    bus.s_axis_tvalid_i = 4'b1111;
    bus.req_mask_i      = 4'b1010;
    bus.m_axis_tready_i = 1'b1;
    #1;
    for (int j = 0; j < 4; j++) begin
      exp_rdy = 4'b0001 << ids[j];
      tests++; if (bus.s_axis_tready_o !== exp_rdy) begin errors++; $display("FAIL mask_tready[%0d] got %b exp %b", j, bus.s_axis_tready_o, exp_rdy); end
      step();
      tests++; if (bus.m_axis_tdata_o !== DW'(8'h20 + ids[j])) begin errors++; $display("FAIL mask_tdata[%0d] got %h exp %h", j, bus.m_axis_tdata_o, DW'(8'h20 + ids[j])); end
      step();
      tests++; if (bus.grant_id_o !== IW'(ids[j])) begin errors++; $display("FAIL mask_grant[%0d] got %0d exp %0d", j, bus.grant_id_o, ids[j]); end
    end
    bus.s_axis_tvalid_i = '0;
    bus.req_mask_i      = 4'b1111;
  endtask

  task automatic test_wrap();
    do_reset();
    bus.s_axis_tdata_i  = {8'h63, 8'h00, 8'h00, 8'h60};
    bus.s_axis_tvalid_i = 4'b1000;
    bus.m_axis_tready_i = 1'b1;
    #1;
    tests++; if (bus.s_axis_tready_o !== 4'b1000) begin errors++; $display("FAIL wrap_first got %b exp 1000", bus.s_axis_tready_o); end
    step();
    bus.s_axis_tvalid_i = 4'b1001;
    step();
    tests++; if (bus.grant_id_o !== 2'd3) begin errors++; $display("FAIL wrap_grant3 got %0d exp 3", bus.grant_id_o); end
    tests++; if (bus.s_axis_tready_o !== 4'b0001) begin errors++; $display("FAIL wrap_to0 got %b exp 0001", bus.s_axis_tready_o); end
    step();
    tests++; if (bus.m_axis_tdata_o !== 8'h60) begin errors++; $display("FAIL wrap_tdata got %h exp 60", bus.m_axis_tdata_o); end
    step();
    tests++; if (bus.grant_id_o !== 2'd0) begin errors++; $display("FAIL wrap_grant0 got %0d exp 0", bus.grant_id_o); end
    tests++; if (bus.s_axis_tready_o !== 4'b1000) begin errors++; $display("FAIL wrap_back3 got %b exp 1000", bus.s_axis_tready_o); end
    bus.s_axis_tvalid_i = '0;
    step();
    step();
  endtask

  task automatic test_reset_during_send();
    do_reset();
    saw_55 = 1'b0;
    bus.s_axis_tdata_i  = {8'h00, 8'h55, 8'h31, 8'h40};
    bus.s_axis_tvalid_i = 4'b0010;
    bus.m_axis_tready_i = 1'b1;
    #1;
    step();
    bus.s_axis_tvalid_i = '0;
    step();
    tests++; if (bus.grant_id_o !== 2'd1) begin errors++; $display("FAIL rs_setup_grant got %0d exp 1", bus.grant_id_o); end
    bus.s_axis_tvalid_i = 4'b0100;
    bus.m_axis_tready_i = 1'b0;
    #1;
    tests++; if (bus.s_axis_tready_o !== 4'b0100) begin errors++; $display("FAIL rs_take55 got %b exp 0100", bus.s_axis_tready_o); end
    step();
    bus.s_axis_tvalid_i = '0;
    #1;
    tests++; if (bus.m_axis_tdata_o !== 8'h55) begin errors++; $display("FAIL rs_held got %h exp 55", bus.m_axis_tdata_o); end
    rst = 1'b1;
    bus.s_axis_tvalid_i = 4'b1111;
    step();
    tests++; if (bus.m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL rs_tvalid got %b exp 0", bus.m_axis_tvalid_o); end
    tests++; if (bus.m_axis_tdata_o !== 8'h00) begin errors++; $display("FAIL rs_tdata got %h exp 00", bus.m_axis_tdata_o); end
    tests++; if (bus.grant_id_o !== 2'd0) begin errors++; $display("FAIL rs_grant got %0d exp 0", bus.grant_id_o); end
    tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL rs_tready_in_reset got %b exp 0000", bus.s_axis_tready_o); end
    rst = 1'b0;
    bus.s_axis_tvalid_i = 4'b0101;
    bus.m_axis_tready_i = 1'b1;
    #1;
    tests++; if (bus.s_axis_tready_o !== 4'b0001) begin errors++; $display("FAIL rs_first_grant got %b exp 0001", bus.s_axis_tready_o); end
    step();
    bus.s_axis_tvalid_i = '0;
    #1;
    tests++; if (bus.m_axis_tdata_o !== 8'h40) begin errors++; $display("FAIL rs_after_tdata got %h exp 40", bus.m_axis_tdata_o); end
    step();
    step();
    tests++; if (saw_55 !== 1'b0) begin errors++; $display("FAIL rs_no55 got %b exp 0", saw_55); end
  endtask

  task automatic test_idle();
    int acc0;
    do_reset();
    acc0 = acc_cnt;
    bus.s_axis_tdata_i  = {8'h00, 8'h00, 8'h00, 8'h77};
    bus.m_axis_tready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tests++; if (bus.s_axis_tready_o !== 4'b0000) begin errors++; $display("FAIL idle_tready[%0d] got %b exp 0000", c, bus.s_axis_tready_o); end
      tests++; if (bus.m_axis_tvalid_o !== 1'b0) begin errors++; $display("FAIL idle_tvalid[%0d] got %b exp 0", c, bus.m_axis_tvalid_o); end
      step();
    end
    bus.s_axis_tvalid_i = 4'b0001;
    #1;
    tests++; if (bus.s_axis_tready_o !== 4'b0001) begin errors++; $display("FAIL idle_still_arb got %b exp 0001", bus.s_axis_tready_o); end
    step();
    bus.s_axis_tvalid_i = '0;
    #1;
    tests++; if (bus.m_axis_tdata_o !== 8'h77) begin errors++; $display("FAIL idle_tdata got %h exp 77", bus.m_axis_tdata_o); end
    step();
    step();
    tests++; if (acc_cnt - acc0 !== 1) begin errors++; $display("FAIL idle_count got %0d exp 1", acc_cnt - acc0); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_mask();
    test_wrap();
    test_reset_during_send();
    test_idle();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
